// File: rtl/subckt_stim_sig_driver_if.sv
// Handshake and data bundle between the stimulus/signature driver and the harness it serves.
// The master side is the driver; the slave side is the sequencer and the subcircuit under test.
interface subckt_stim_sig_driver_if #(
  parameter int unsigned N_IN = 5
);
  logic            start;
  logic            resp_i;
  logic [15:0]     golden_i;
  logic [N_IN-1:0] stim_o;
  logic            busy;
  logic            done;
  logic            match_o;
  logic [15:0]     signature_o;
  logic [15:0]     vec_cnt_o;

  modport master (
    input  start, resp_i, golden_i,
    output stim_o, busy, done, match_o, signature_o, vec_cnt_o
  );

  modport slave (
    output start, resp_i, golden_i,
    input  stim_o, busy, done, match_o, signature_o, vec_cnt_o
  );
endinterface

// File: rtl/subckt_stim_sig_driver.sv
// Drives LFSR vectors into a small registered subcircuit and compacts its delayed response
// into a 16-bit MISR signature, then compares that signature against a golden value.
module subckt_stim_sig_driver #(
  parameter int unsigned N_IN     = 5,
  parameter int unsigned LAT      = 2,
  parameter int unsigned NUM_VEC  = 1000,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [15:0] SIG_POLY = 16'h1021
) (
  input  logic                   I1470,
  input  logic                   I1477,
  subckt_stim_sig_driver_if.master bus
);

  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LAST_VEC   = 16'(NUM_VEC - 1);
  localparam logic [3:0]  LAST_DRAIN = 4'(LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000) ^ {15'h0000, b};
  endfunction

  state_t          state_r, state_s;
  logic [15:0]     lfsr_r, lfsr_s;
  logic [15:0]     sig_r, sig_s;
  logic [15:0]     vec_cnt_r, vec_cnt_s;
  logic [3:0]      drain_cnt_r, drain_cnt_s;
  logic [LAT-1:0]  vld_r, vld_s;
  logic [N_IN-1:0] stim_r, stim_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            match_r, match_s;

  // Next-state, datapath and output decode; outputs are computed from the next state so they leave flops
  always_comb begin
    state_s     = state_r;
    lfsr_s      = lfsr_r;
    vec_cnt_s   = vec_cnt_r;
    drain_cnt_s = drain_cnt_r;
    match_s     = match_r;
    vld_s       = vld_r << 1;
    vld_s[0]    = (state_r == ST_RUN);
    // The valid tap marks the cycle in which the response to an earlier vector arrives
    if (vld_r[LAT-1]) begin
      sig_s = misr_step(sig_r, bus.resp_i);
    end else begin
      sig_s = sig_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s   = ST_RUN;
          lfsr_s    = SEED_EFF;
          sig_s     = 16'h0000;
          vec_cnt_s = 16'h0000;
          match_s   = 1'b0;
          vld_s     = {LAT{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        lfsr_s    = lfsr_step(lfsr_r);
        vec_cnt_s = vec_cnt_r + 16'd1;
        if (vec_cnt_r == LAST_VEC) begin
          state_s     = ST_DRAIN;
          drain_cnt_s = 4'd0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == LAST_DRAIN) begin
          state_s = ST_DONE;
          match_s = (sig_s == bus.golden_i);
        end else begin
          drain_cnt_s = drain_cnt_r + 4'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    stim_s = (state_s == ST_RUN) ? lfsr_s[N_IN-1:0] : {N_IN{1'b0}};
    busy_s = (state_s == ST_RUN) || (state_s == ST_DRAIN);
    done_s = (state_s == ST_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= SEED_EFF;
      sig_r       <= 16'h0000;
      vec_cnt_r   <= 16'h0000;
      drain_cnt_r <= 4'd0;
      vld_r       <= {LAT{1'b0}};
      stim_r      <= {N_IN{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      match_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      lfsr_r      <= lfsr_s;
      sig_r       <= sig_s;
      vec_cnt_r   <= vec_cnt_s;
      drain_cnt_r <= drain_cnt_s;
      vld_r       <= vld_s;
      stim_r      <= stim_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      match_r     <= match_s;
    end
  end

  assign bus.stim_o      = stim_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.match_o     = match_r;
  assign bus.signature_o = sig_r;
  assign bus.vec_cnt_o   = vec_cnt_r;

endmodule

// File: tb/tb_subckt_stim_sig_driver.sv
// Randomized bench: a reference model predicts the vector stream, the busy/done timing
// and the folded signature of each run from the stimulus/response rules.
module tb_subckt_stim_sig_driver;
  localparam int unsigned N_IN    = 5;
  localparam int unsigned LAT     = 2;
  localparam int unsigned NUM_VEC = 6;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam logic [15:0] POLY    = 16'h1021;
  localparam int          TOTAL   = NUM_VEC + LAT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  subckt_stim_sig_driver_if #(.N_IN(N_IN)) bus ();

  subckt_stim_sig_driver #(
    .N_IN(N_IN), .LAT(LAT), .NUM_VEC(NUM_VEC), .SEED(SEED), .SIG_POLY(POLY)
  ) u_dut (
    .I1470(clk),
    .I1477(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: k-th stimulus word is the seed advanced k times by the Fibonacci recurrence
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference: signature as polynomial division of the response stream, one bit at a time
  function automatic logic [15:0] fold(input logic [15:0] s, input logic b);
    int unsigned t;
    t = (int'(s) * 2) ^ int'(b);
    if (t >= 65536) t = (t - 65536) ^ int'(POLY);
    return 16'(t);
  endfunction

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_stim"}, 32'(bus.stim_o), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_done"}, 32'(bus.done), 32'd0);
    check_val({tag, "_match"}, 32'(bus.match_o), 32'd0);
    check_val({tag, "_sig"}, 32'(bus.signature_o), 32'd0);
    check_val({tag, "_vcnt"}, 32'(bus.vec_cnt_o), 32'd0);
  endtask

  // mode 0: resp tied 0, 1: tied 1, 2: random bits, 3: parity of delayed stimulus under a mask
  task automatic do_run(input int mode, input bit want_match, input bit poke_start);
    logic [N_IN-1:0] exp_stim [NUM_VEC];
    logic            resp_seq [TOTAL];
    logic [15:0]     lf, sig_exp, gold;
    logic [N_IN-1:0] mask, s_exp;
    mask = N_IN'($urandom);
    lf = SEED;
    for (int k = 0; k < NUM_VEC; k++) begin
      exp_stim[k] = lf[N_IN-1:0];
      lf = lfsr_adv(lf);
    end
    for (int r = 0; r < TOTAL; r++) begin
      case (mode)
        0: resp_seq[r] = 1'b0;
        1: resp_seq[r] = 1'b1;
        2: resp_seq[r] = 1'($urandom);
        default: resp_seq[r] = (r >= LAT) ? ^(exp_stim[r-LAT] & mask) : 1'b0;
      endcase
    end
    sig_exp = 16'h0000;
    for (int r = LAT; r < TOTAL; r++) sig_exp = fold(sig_exp, resp_seq[r]);
    gold = want_match ? sig_exp : (sig_exp ^ 16'($urandom_range(1, 65535)));

    @(negedge clk);
    check_val("idle_busy", 32'(bus.busy), 32'd0);
    bus.golden_i = gold;
    bus.start    = 1'b1;
    bus.resp_i   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int r = 0; r <= TOTAL; r++) begin
      if (r < NUM_VEC) s_exp = exp_stim[r];
      else             s_exp = {N_IN{1'b0}};
      check_val("stim", 32'(bus.stim_o), 32'(s_exp));
      check_val("busy", 32'(bus.busy), 32'(r < TOTAL));
      check_val("done", 32'(bus.done), 32'(r == TOTAL));
      if (r == TOTAL) begin
        check_val("sig_done", 32'(bus.signature_o), 32'(sig_exp));
        check_val("match_done", 32'(bus.match_o), 32'(want_match));
        check_val("vcnt_done", 32'(bus.vec_cnt_o), NUM_VEC);
      end
      bus.resp_i = (r < TOTAL) ? resp_seq[r] : 1'b0;
      bus.start  = poke_start && (r == 1 || r == TOTAL);
      @(negedge clk);
    end
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("post_busy", 32'(bus.busy), 32'd0);
      check_val("post_done", 32'(bus.done), 32'd0);
      check_val("post_stim", 32'(bus.stim_o), 32'd0);
      check_val("post_sig", 32'(bus.signature_o), 32'(sig_exp));
      check_val("post_vcnt", 32'(bus.vec_cnt_o), NUM_VEC);
      check_val("post_match", 32'(bus.match_o), 32'(want_match));
      @(negedge clk);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.resp_i   = 1'b0;
    bus.golden_i = 16'h0000;
    #1;
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_run(0, 1'b1, 1'b0);
    do_run(1, 1'b1, 1'b1);
    do_run(1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_run(2, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) do_run(3, 1'($urandom), 1'b0);

    // Abort mid-run: everything must clear immediately and no done may follow
    @(negedge clk);
    bus.resp_i = 1'b1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < TOTAL + 2; i++) begin
      check_val("abort_done", 32'(bus.done), 32'd0);
      check_val("abort_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end

    do_run(3, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
